// File: rtl/axppa_three_operand_adder_pipe.sv
// Three-operand adder: 3:2 carry-save row, then a Kogge-Stone prefix with an optional approximate low region.
// Latency 3 cycles (S1 p/g, S2 prefix carries, S3 sum); throughput 1 result per cycle.
// A stalled output (out_valid & ~out_ready) freezes every stage; in_ready = ~out_valid | out_ready.
module axppa_three_operand_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_input,
    input  logic [WIDTH-1:0]   b_input,
    input  logic [WIDTH-1:0]   c_input,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   sum_output,
    output logic               out_approx
);

    localparam int N      = WIDTH + 1;
    localparam int LEVELS = $clog2(N);

    // h is the per-bit half sum used for the final XOR; p/g feed the prefix tree.
    typedef struct packed {
        logic         mode;
        logic [N-1:0] h;
        logic [N-1:0] p;
        logic [N-1:0] g;
    } s1_t;

    typedef struct packed {
        logic         mode;
        logic [N-1:0] h;
        logic [N:0]   carry;
    } s2_t;

    logic         adv;
    logic         s1_vld;
    logic         s2_vld;
    s1_t          s1_q;
    s1_t          s1_nxt;
    s2_t          s2_q;
    s2_t          s2_nxt;
    logic [N-1:0] s_vec;
    logic [N-1:0] cv_vec;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign s_vec  = {1'b0, a_input ^ b_input ^ c_input};
    assign cv_vec = {(a_input & b_input) | (a_input & c_input) | (b_input & c_input), 1'b0};

    // In approximate mode the low region has p=g=0 so no carry ripples through it;
    // only its top bit generates the carry into bit APPROX_BITS.
    always_comb begin
        s1_nxt      = '0;
        s1_nxt.mode = approx_en;
        for (int i = 0; i < N; i++) begin
            if (approx_en && (i < APPROX_BITS)) begin
                s1_nxt.h[i] = s_vec[i] | cv_vec[i];
                s1_nxt.p[i] = 1'b0;
                s1_nxt.g[i] = (i == APPROX_BITS - 1) ? (s_vec[i] & cv_vec[i]) : 1'b0;
            end else begin
                s1_nxt.h[i] = s_vec[i] ^ cv_vec[i];
                s1_nxt.p[i] = s_vec[i] ^ cv_vec[i];
                s1_nxt.g[i] = s_vec[i] & cv_vec[i];
            end
        end
    end

    // Kogge-Stone: walking i downward lets each level update in place.
    always_comb begin : prefix
        logic [N-1:0] gl;
        logic [N-1:0] pl;
        gl = s1_q.g;
        pl = s1_q.p;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = N - 1; i >= (1 << l); i--) begin
                gl[i] = gl[i] | (pl[i] & gl[i - (1 << l)]);
                pl[i] = pl[i] & pl[i - (1 << l)];
            end
        end
        s2_nxt       = '0;
        s2_nxt.mode  = s1_q.mode;
        s2_nxt.h     = s1_q.h;
        s2_nxt.carry = {gl, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            out_valid  <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            sum_output <= '0;
            out_approx <= 1'b0;
        end else if (adv) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (in_valid) begin
                s1_q <= s1_nxt;
            end
            if (s1_vld) begin
                s2_q <= s2_nxt;
            end
            if (s2_vld) begin
                sum_output <= {s2_q.carry[N], s2_q.h ^ s2_q.carry[N-1:0]};
                out_approx <= s2_q.mode;
            end
        end
    end

endmodule

// File: tb/tb_axppa_three_operand_adder_pipe.sv
// Bench for axppa_three_operand_adder_pipe: several parameterisations run in lockstep on one stimulus stream,
// each output compared against an arithmetic reference model.
module tb_axppa_three_operand_adder_pipe;

    localparam int NCFG = 13;

    function automatic int cfg_w(int g);
        if (g == 0) return 16;
        else if (g <= 3) return 4;
        else if (g <= 6) return 16;
        else if (g <= 9) return 33;
        else return 64;
    endfunction

    function automatic int cfg_k(int g);
        int sel;
        if (g == 0) return 4;
        sel = (g - 1) % 3;
        if (sel == 0) return 0;
        else if (sel == 1) return 1;
        else return cfg_w(g) - 1;
    endfunction

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic        ap;
    } item_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        approx_en;
    logic [63:0] a_all;
    logic [63:0] b_all;
    logic [63:0] c_all;

    logic        in_ready_o   [NCFG];
    logic        out_valid_o  [NCFG];
    logic        out_approx_o [NCFG];
    logic [65:0] sum_o        [NCFG];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    item_t exp_q[$];

    logic        stall_prev = 1'b0;
    logic [65:0] prev_sum [NCFG];
    logic        prev_ap  [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : gen_dut
        localparam int W = cfg_w(g);
        localparam int K = cfg_k(g);
        logic [W+1:0] sum_w;
        axppa_three_operand_adder_pipe #(.WIDTH(W), .APPROX_BITS(K)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_ready   (in_ready_o[g]),
            .a_input    (a_all[W-1:0]),
            .b_input    (b_all[W-1:0]),
            .c_input    (c_all[W-1:0]),
            .approx_en  (approx_en),
            .out_valid  (out_valid_o[g]),
            .out_ready  (out_ready),
            .sum_output (sum_w),
            .out_approx (out_approx_o[g])
        );
        assign sum_o[g] = 66'(sum_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] model(int w, int k, logic [63:0] a0, logic [63:0] b0,
                                          logic [63:0] c0, logic ap);
        logic [65:0] a, b, c, s, cv, low, high, msk;
        logic        cin;
        msk = (66'd1 << w) - 66'd1;
        a   = {2'b00, a0} & msk;
        b   = {2'b00, b0} & msk;
        c   = {2'b00, c0} & msk;
        if (!ap || k == 0) return a + b + c;
        s    = a ^ b ^ c;
        cv   = ((a & b) | (a & c) | (b & c)) << 1;
        low  = (s | cv) & ((66'd1 << k) - 66'd1);
        cin  = s[k-1] & cv[k-1];
        high = (s >> k) + (cv >> k) + {65'd0, cin};
        return (high << k) | low;
    endfunction

    task automatic check(string name, logic [65:0] act, logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: everything is sampled on the falling edge and describes the rising edge that follows.
    always @(negedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("in_ready_rule[%0d]", g), {65'd0, in_ready_o[g]},
                  {65'd0, ~out_valid_o[g] | out_ready});
            check($sformatf("valid_lockstep[%0d]", g), {65'd0, out_valid_o[g]}, {65'd0, out_valid_o[0]});
        end
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                for (int g = 0; g < NCFG; g++) begin
                    check($sformatf("stall_valid[%0d]", g), {65'd0, out_valid_o[g]}, 66'd1);
                    check($sformatf("stall_sum[%0d]", g), sum_o[g], prev_sum[g]);
                    check($sformatf("stall_approx[%0d]", g), {65'd0, out_approx_o[g]}, {65'd0, prev_ap[g]});
                end
            end
            if (out_valid_o[0] && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", sum_o[0], 66'h3_FFFF_FFFF_FFFF_FFFF ^ sum_o[0]);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    for (int g = 0; g < NCFG; g++) begin
                        check($sformatf("sum[w%0d k%0d]", cfg_w(g), cfg_k(g)), sum_o[g],
                              model(cfg_w(g), cfg_k(g), it.a, it.b, it.c, it.ap));
                        check($sformatf("out_approx[%0d]", g), {65'd0, out_approx_o[g]}, {65'd0, it.ap});
                    end
                end
            end
            if (in_valid && in_ready_o[0]) begin
                item_t ni;
                ni.a  = a_all;
                ni.b  = b_all;
                ni.c  = c_all;
                ni.ap = approx_en;
                exp_q.push_back(ni);
            end
            stall_prev = out_valid_o[0] && !out_ready;
            for (int g = 0; g < NCFG; g++) begin
                prev_sum[g] = sum_o[g];
                prev_ap[g]  = out_approx_o[g];
            end
        end
    end

    function automatic logic [63:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sel == 1) return 64'd0;
        else return {$urandom, $urandom};
    endfunction

    task automatic drive_rand(logic v);
        in_valid  = v;
        a_all     = rand_op();
        b_all     = rand_op();
        c_all     = rand_op();
        approx_en = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One triple through an idle pipe; results appear in the third cycle after the accepting edge.
    task automatic direct(logic [63:0] a, logic [63:0] b, logic [63:0] c, logic ap);
        in_valid  = 1'b1;
        a_all     = a;
        b_all     = b;
        c_all     = c;
        approx_en = ap;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("latency_e1", {65'd0, out_valid_o[0]}, 66'd0);
        step();
        check("latency_e2", {65'd0, out_valid_o[0]}, 66'd0);
        step();
        check("latency_e3", {65'd0, out_valid_o[0]}, 66'd1);
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        check("drain_pending", 66'(exp_q.size()), 66'd0);
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        approx_en = 1'b0;
        a_all     = '0;
        b_all     = '0;
        c_all     = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_out_valid", {65'd0, out_valid_o[0]}, 66'd0);
        check("reset_sum", sum_o[0], 66'd0);
        check("reset_approx", {65'd0, out_approx_o[0]}, 66'd0);
        check("reset_in_ready", {65'd0, in_ready_o[0]}, 66'd1);

        direct(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("max_w16", sum_o[0], 66'h2FFFD);
        check("max_w16_approx", {65'd0, out_approx_o[0]}, 66'd0);
        check("max_w4", sum_o[1], 66'h2D);
        check("max_w33", sum_o[7], 66'h5_FFFF_FFFD);
        check("max_w64", sum_o[10], 66'h2_FFFF_FFFF_FFFF_FFFD);
        step();

        direct(64'h000F, 64'h0001, 64'h0000, 1'b1);
        check("approx_k4", sum_o[0], 66'h0000E);
        check("approx_k4_flag", {65'd0, out_approx_o[0]}, 66'd1);
        check("approx_k0_exact", sum_o[4], 66'h10);
        check("approx_k1", sum_o[5], 66'h10);
        check("approx_k15", sum_o[6], 66'hE);
        step();

        direct(64'h000F, 64'h0001, 64'h0000, 1'b0);
        check("exact_k4", sum_o[0], 66'h00010);
        check("exact_k4_flag", {65'd0, out_approx_o[0]}, 66'd0);
        step();

        // Streaming at full rate: exactly one retirement per cycle.
        base = n_out;
        for (int i = 0; i < 1000; i++) begin
            drive_rand(1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        check("stream_throughput", 66'(n_out - base), 66'd1000);
        drain();

        // Random backpressure with continuous input.
        for (int i = 0; i < 1000; i++) begin
            drive_rand(1'b1);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Reset with three triples in flight and a fourth presented on the reset cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step();
        end
        check("rst_pipe_full", 66'(exp_q.size()), 66'd3);
        drive_rand(1'b1);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("midrst_valid[%0d]", g), {65'd0, out_valid_o[g]}, 66'd0);
            check($sformatf("midrst_sum[%0d]", g), sum_o[g], 66'd0);
            check($sformatf("midrst_approx[%0d]", g), {65'd0, out_approx_o[g]}, 66'd0);
        end
        out_ready = 1'b1;
        base      = n_out;
        for (int i = 0; i < 8; i++) step();
        check("midrst_no_output", 66'(n_out - base), 66'd0);

        // Short mixed run after reset to confirm the pipe resumes cleanly.
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
